axis_frame_arb: RTL and testbench
=================================

Name: axis_frame_arb

Overview:
- Frame-aware round-robin arbiter that shares one AXI-Stream sink (typically an axis_fifo in FRAME_FIFO mode) among S_COUNT source ports.
- Once a source is granted, it holds the grant until its tlast beat is accepted, so frames are never interleaved in the downstream FIFO.
- Output is a single registered stage; the downstream FIFO input connects directly to the m_axis side.

Parameters:
- S_COUNT, 4: number of source ports, 2..16.
- DATA_WIDTH, 8: tdata width per port.
- KEEP_ENABLE, (DATA_WIDTH>8): carry tkeep; when 0, m_axis_tkeep is driven all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width.
- ID_WIDTH, 8: tid width.
- DEST_WIDTH, 8: tdest width.
- USER_WIDTH, 1: tuser width.
- CL_S_COUNT, $clog2(S_COUNT): grant index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  flattened source data; port i occupies slice i.
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  flattened tkeep.
- s_axis_tvalid  in  S_COUNT  per-port valid.
- s_axis_tready  out  S_COUNT  per-port ready.
- s_axis_tlast  in  S_COUNT  per-port last.
- s_axis_tid  in  S_COUNT*ID_WIDTH  flattened tid.
- s_axis_tdest  in  S_COUNT*DEST_WIDTH  flattened tdest.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  flattened tuser.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output tkeep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- m_axis_tid  out  ID_WIDTH  output tid.
- m_axis_tdest  out  DEST_WIDTH  output tdest.
- m_axis_tuser  out  USER_WIDTH  output tuser.
- grant_valid  out  1  a frame is in progress.
- grant_index  out  CL_S_COUNT  index of the granted port; valid only while grant_valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - m_axis_tvalid, grant_valid and s_axis_tready are all 0.
  - All m_axis data fields are 0 and grant_index is 0.
  - The round-robin pointer is set so that port 0 has highest priority on the first arbitration.
- Output register:
  - out_ready = m_axis_tready | ~m_axis_tvalid.
  - A beat accepted from the granted port appears on m_axis on the next cycle (1-cycle latency).
  - m_axis fields hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- FSM state IDLE:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is high, select the first valid port scanning upward from (last_grant+1) mod S_COUNT, wrapping.
  - Register the selection as grant_index, set grant_valid=1, go to BUSY.
  - The grant therefore takes effect one cycle after the request.
- FSM state BUSY:
  - s_axis_tready[grant_index] = out_ready; all other ready bits are 0.
  - On a handshake with s_axis_tlast=1: update last_grant to grant_index, clear grant_valid and go to IDLE.
  - The next arbitration occurs the following cycle, leaving exactly one idle input cycle between frames.
  - A beat with tlast=0 stays in BUSY.
- Source tvalid dropping mid-frame: hold the grant and wait. No timeout exists and no other port may be granted.
- Single requester: it is re-granted after each frame with the same 1-cycle gap.
- Simultaneous events:
  - Requests arriving while BUSY wait for IDLE.
  - A new request arriving in the same cycle as the current tlast handshake is considered at the next IDLE arbitration.
- Reset mid-frame: the frame is truncated without a tlast on m_axis; the downstream FIFO is reset on the same rst_n.
- Field pass-through:
  - tid, tdest and tuser are copied unmodified.
  - tkeep is copied when KEEP_ENABLE=1, otherwise all-ones.
- No arithmetic beyond index wrap: the pointer increment is mod S_COUNT and must be correct for S_COUNT values that are not a power of two.

Decomposition:
- Shared package (axis_pkg): the state enum {IDLE, BUSY} and a clog2-based index-width function reused by the FIFO and by future mux and demux blocks.
- One natural sub-module: axis_rr_select, a combinational round-robin priority encoder.
  - Inputs: request vector and last_grant.
  - Outputs: index and found flag.
  - Kept separate so it can be reused by future switch blocks.

Test Plan:
- Single frame: port 2 sends data 0x11, 0x22, 0x33 (tlast on 0x33) with m_axis_tready=1 -> grant_index=2 one cycle after request; m_axis shows 0x11, 0x22, 0x33 on consecutive cycles with tlast on 0x33; grant_valid falls after the tlast handshake.
- Contention: ports 0, 1 and 3 each hold one-beat frames with data 0xA0, 0xA1, 0xA3 from reset -> output order 0xA0, 0xA1, 0xA3, with one idle cycle between frames.
- Fairness wrap: after port 3 is served, ports 0 and 3 request again -> port 0 is granted first, then port 3.
- Backpressure: m_axis_tready=0 for 3 cycles mid-frame -> m_axis data held stable, s_axis_tready[grant]=0 during the stall, no beat lost or duplicated.
- Mid-frame stall: the granted port drops tvalid for 2 cycles while port 1 requests -> port 1 is not granted until the first frame's tlast completes.
- Async reset during BUSY: rst_n asserted low mid-cycle -> m_axis_tvalid=0 and grant_valid=0 immediately; after release, port 0 wins first arbitration when all ports request.

Source files
------------

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream infrastructure blocks (frame arbiter,
// FIFO, and the mux/demux blocks that will reuse the round-robin selector).
//   arb_state_e : frame-arbiter state, IDLE (arbitrating) or BUSY (frame owned)
//   idx_width() : width of an index able to address n ports (minimum 1 bit)
// -----------------------------------------------------------------------------
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // A single port still needs a 1-bit index so port widths never collapse to 0.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_select.sv
// -----------------------------------------------------------------------------
// axis_rr_select
// Combinational round-robin priority encoder. Scans the request vector upward
// from (last_grant + 1) mod S_COUNT, wrapping, and reports the first hit.
// Ports:
//   req        in  S_COUNT     request bit per port
//   last_grant in  CL_S_COUNT  port served most recently (lowest priority now)
//   index      out CL_S_COUNT  selected port, 0 when nothing is requested
//   found      out 1           at least one request is present
// -----------------------------------------------------------------------------
module axis_rr_select
  import axis_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int CL_S_COUNT = idx_width(S_COUNT)
) (
  input  logic [S_COUNT-1:0]    req,
  input  logic [CL_S_COUNT-1:0] last_grant,
  output logic [CL_S_COUNT-1:0] index,
  output logic                  found
);

  // One extra bit holds last_grant + offset (at most 2*S_COUNT-1) before the
  // wrap, so the modulo works for port counts that are not a power of two.
  localparam int CW = CL_S_COUNT + 1;

  logic [CW-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    index = '0;
    found = 1'b0;
    cand  = '0;
    // Walk from the farthest offset to the nearest so the nearest hit,
    // i.e. the highest-priority port, is the one that sticks.
    for (int off = S_COUNT; off >= 1; off--) begin
      cand = {1'b0, last_grant} + CW'(off);
      if (cand >= CW'(S_COUNT)) begin
        cand = cand - CW'(S_COUNT);
      end
      if (req[cand[CL_S_COUNT-1:0]]) begin
        index = cand[CL_S_COUNT-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arb.sv
// -----------------------------------------------------------------------------
// axis_frame_arb
// Frame-aware round-robin arbiter sharing one AXI-Stream sink among S_COUNT
// sources. A granted source keeps the grant until its tlast beat is accepted,
// so frames never interleave downstream. The output is one register stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_*            flattened source buses, port i occupies slice i
//   s_axis_tready       per-port ready, only the granted port is ever ready
//   m_axis_*            registered output stream
//   grant_valid         a frame is in progress
//   grant_index         granted port, meaningful while grant_valid=1
// -----------------------------------------------------------------------------
module axis_frame_arb
  import axis_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int CL_S_COUNT  = idx_width(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          grant_valid,
  output logic [CL_S_COUNT-1:0]         grant_index
);

  arb_state_e              state_q, state_d;
  logic [CL_S_COUNT-1:0]   grant_index_q, grant_index_d;
  logic [CL_S_COUNT-1:0]   last_grant_q, last_grant_d;

  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [ID_WIDTH-1:0]     m_tid_q, m_tid_d;
  logic [DEST_WIDTH-1:0]   m_tdest_q, m_tdest_d;
  logic [USER_WIDTH-1:0]   m_tuser_q, m_tuser_d;

  logic                    out_ready;
  logic                    accept;
  logic                    frame_end;
  logic [CL_S_COUNT-1:0]   sel_index;
  logic                    sel_found;

  // The output register can take a beat when it is empty or being drained.
  assign out_ready = m_axis_tready | ~m_tvalid_q;
  assign accept    = (state_q == BUSY) & s_axis_tvalid[grant_index_q] & out_ready;
  assign frame_end = accept & s_axis_tlast[grant_index_q];

  axis_rr_select #(
    .S_COUNT    (S_COUNT),
    .CL_S_COUNT (CL_S_COUNT)
  ) u_rr_select (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .index      (sel_index),
    .found      (sel_found)
  );

  // State register plus the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is updated only with non-blocking assignments so
      // every flop samples values from before the edge.
      state_q       <= IDLE;
      grant_index_q <= '0;
      // Port 0 is the first port after S_COUNT-1, so it wins first after reset.
      last_grant_q  <= CL_S_COUNT'(S_COUNT - 1);
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tid_q       <= '0;
      m_tdest_q     <= '0;
      m_tuser_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      last_grant_q  <= last_grant_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tid_q       <= m_tid_d;
      m_tdest_q     <= m_tdest_d;
      m_tuser_q     <= m_tuser_d;
    end
  end

  // Next-state logic. Requests seen while BUSY, including one arriving with the
  // closing tlast, are picked up by the IDLE arbitration on the following cycle.
  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    last_grant_d  = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_index_d = sel_index;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        // A source that drops tvalid mid-frame simply stalls the grant.
        if (frame_end) begin
          last_grant_d = grant_index_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only the granted port sees ready, and only while BUSY.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      s_axis_tready[grant_index_q] = out_ready;
    end
  end

  // Output register datapath: load on accept, otherwise hold while stalled.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    m_tdest_d  = m_tdest_q;
    m_tuser_d  = m_tuser_q;
    if (out_ready) begin
      m_tvalid_d = accept;
    end
    if (accept) begin
      m_tdata_d = s_axis_tdata[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
      m_tkeep_d = s_axis_tkeep[grant_index_q*KEEP_WIDTH +: KEEP_WIDTH];
      m_tlast_d = s_axis_tlast[grant_index_q];
      m_tid_d   = s_axis_tid[grant_index_q*ID_WIDTH +: ID_WIDTH];
      m_tdest_d = s_axis_tdest[grant_index_q*DEST_WIDTH +: DEST_WIDTH];
      m_tuser_d = s_axis_tuser[grant_index_q*USER_WIDTH +: USER_WIDTH];
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? m_tkeep_q : {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tdest  = m_tdest_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant_valid   = (state_q == BUSY);
  assign grant_index   = grant_index_q;

endmodule

// File: tb/tb_axis_frame_arb.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arb
// Directed bench for axis_frame_arb with default parameters (4 ports, 8-bit
// data, tkeep disabled). Sources present tid = data^0x5A, tdest = 0x10+port,
// tuser = data[0] so pass-through fields can be predicted from the data byte.
// -----------------------------------------------------------------------------
module tb_axis_frame_arb;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 8;
  localparam int TW = 8;
  localparam int UW = 1;
  localparam int CL = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [S*DW-1:0] s_tdata;
  logic [S*KW-1:0] s_tkeep;
  logic [S-1:0]    s_tvalid;
  logic [S-1:0]    s_tready;
  logic [S-1:0]    s_tlast;
  logic [S*IW-1:0] s_tid;
  logic [S*TW-1:0] s_tdest;
  logic [S*UW-1:0] s_tuser;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic [TW-1:0]   m_tdest;
  logic [UW-1:0]   m_tuser;
  logic            grant_valid;
  logic [CL-1:0]   grant_index;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  axis_frame_arb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tid    (s_tid),
    .s_axis_tdest  (s_tdest),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tdest  (m_tdest),
    .m_axis_tuser  (m_tuser),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every accepted output beat, sampled mid-cycle.
  logic [7:0] mon_d[$];
  logic       mon_l[$];
  int         mon_c[$];

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      mon_d.push_back(m_tdata);
      mon_l.push_back(m_tlast);
      mon_c.push_back(cyc);
    end
  end

  task automatic mon_clear();
    mon_d.delete();
    mon_l.delete();
    mon_c.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic v, input logic [7:0] d, input logic l);
    s_tvalid[i]       = v;
    s_tdata[i*8 +: 8] = d;
    s_tlast[i]        = l;
    s_tkeep[i]        = 1'b0;
    s_tid[i*8 +: 8]   = d ^ 8'h5A;
    s_tdest[i*8 +: 8] = 8'(i) + 8'h10;
    s_tuser[i]        = d[0];
  endtask

  task automatic idle_all();
    for (int i = 0; i < S; i++) set_port(i, 1'b0, 8'h00, 1'b0);
  endtask

  // Queued single-stream sources used by the multi-frame scenarios.
  logic [7:0] src_d [S][8];
  logic       src_l [S][8];
  int         src_n [S];
  int         src_p [S];

  task automatic clear_src();
    for (int i = 0; i < S; i++) begin
      src_n[i] = 0;
      src_p[i] = 0;
    end
  endtask

  task automatic add_beat(input int i, input logic [7:0] d, input logic l);
    src_d[i][src_n[i]] = d;
    src_l[i][src_n[i]] = l;
    src_n[i]++;
  endtask

  task automatic present(input int i);
    if (src_p[i] < src_n[i]) set_port(i, 1'b1, src_d[i][src_p[i]], src_l[i][src_p[i]]);
    else                     set_port(i, 1'b0, 8'h00, 1'b0);
  endtask

  // Runs the queued sources for n cycles with the sink always ready.
  task automatic pump(input int n);
    logic [S-1:0] hs;
    m_tready = 1'b1;
    for (int i = 0; i < S; i++) present(i);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      step();
      for (int i = 0; i < S; i++) begin
        if (hs[i]) src_p[i]++;
        present(i);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < S; i++) set_port(i, 1'b1, 8'hEE, 1'b1);
    m_tready = 1'b1;
    #1 rst_n = 1'b0;
    step();
    step();
    checks++;
    if (m_tvalid !== 1'b0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: tvalid=%b grant_valid=%b expected 0 0", m_tvalid, grant_valid);
    end
    checks++;
    if (s_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_s_tready: got %b expected 0000", s_tready);
    end
    checks++;
    if ({m_tdata, m_tlast, m_tid, m_tdest, m_tuser, grant_index} !== '0) begin
      errors++;
      $display("FAIL reset_fields: data=%h last=%b id=%h dest=%h user=%b idx=%0d expected all 0",
               m_tdata, m_tlast, m_tid, m_tdest, m_tuser, grant_index);
    end
    idle_all();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_frame();
    idle_all();
    mon_clear();
    m_tready = 1'b1;
    set_port(2, 1'b1, 8'h11, 1'b0);
    #1;
    checks++;
    if (s_tready !== 4'b0000 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: s_tready=%b grant_valid=%b expected 0000 0", s_tready, grant_valid);
    end
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd2 || s_tready !== 4'b0100 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gv=%b idx=%0d s_tready=%b m_tvalid=%b expected 1 2 0100 0",
               grant_valid, grant_index, s_tready, m_tvalid);
    end
    step();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, 8'h11, 1'b0}) begin
      errors++;
      $display("FAIL single_beat0: v=%b d=%h l=%b expected 1 11 0", m_tvalid, m_tdata, m_tlast);
    end
    checks++;
    if (m_tid !== 8'h4B || m_tdest !== 8'h12 || m_tuser !== 1'b1 || m_tkeep !== 1'b1) begin
      errors++;
      $display("FAIL single_fields: id=%h dest=%h user=%b keep=%b expected 4b 12 1 1",
               m_tid, m_tdest, m_tuser, m_tkeep);
    end
    set_port(2, 1'b1, 8'h22, 1'b0);
    step();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast} !== {1'b1, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL single_beat1: v=%b d=%h l=%b expected 1 22 0", m_tvalid, m_tdata, m_tlast);
    end
    set_port(2, 1'b1, 8'h33, 1'b1);
    step();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, grant_valid} !== {1'b1, 8'h33, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_beat2: v=%b d=%h l=%b gv=%b expected 1 33 1 0",
               m_tvalid, m_tdata, m_tlast, grant_valid);
    end
    set_port(2, 1'b0, 8'h00, 1'b0);
    step();
    checks++;
    if (m_tvalid !== 1'b0 || mon_d.size() !== 3) begin
      errors++;
      $display("FAIL single_end: m_tvalid=%b beats=%0d expected 0 3", m_tvalid, mon_d.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_contention();
    logic [7:0] exp_d [3] = '{8'hA0, 8'hA1, 8'hA3};
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_src();
    mon_clear();
    add_beat(0, 8'hA0, 1'b1);
    add_beat(1, 8'hA1, 1'b1);
    add_beat(3, 8'hA3, 1'b1);
    pump(12);
    checks++;
    if (mon_d.size() !== 3) begin
      errors++;
      $display("FAIL contention_count: got %0d beats expected 3", mon_d.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= mon_d.size()) begin
        errors++;
        $display("FAIL contention_beat%0d: missing, expected %h", k, exp_d[k]);
      end else if (mon_d[k] !== exp_d[k] || mon_l[k] !== 1'b1) begin
        errors++;
        $display("FAIL contention_beat%0d: got %h last=%b expected %h last=1", k, mon_d[k], mon_l[k], exp_d[k]);
      end else if (k > 0 && mon_c[k] - mon_c[k-1] != 2) begin
        errors++;
        $display("FAIL contention_gap%0d: got %0d cycles expected 2", k, mon_c[k] - mon_c[k-1]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fairness_wrap();
    logic [7:0] exp_d [4] = '{8'hB0, 8'hB3, 8'hC0, 8'hC3};
    clear_src();
    mon_clear();
    add_beat(0, 8'hB0, 1'b1);
    add_beat(0, 8'hC0, 1'b1);
    add_beat(3, 8'hB3, 1'b1);
    add_beat(3, 8'hC3, 1'b1);
    pump(14);
    checks++;
    if (mon_d.size() !== 4) begin
      errors++;
      $display("FAIL fairness_count: got %0d beats expected 4", mon_d.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= mon_d.size()) begin
        errors++;
        $display("FAIL fairness_beat%0d: missing, expected %h", k, exp_d[k]);
      end else if (mon_d[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL fairness_beat%0d: got %h expected %h", k, mon_d[k], exp_d[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_requester();
    clear_src();
    mon_clear();
    add_beat(2, 8'hE1, 1'b1);
    add_beat(2, 8'hE2, 1'b1);
    pump(10);
    checks++;
    if (mon_d.size() !== 2) begin
      errors++;
      $display("FAIL single_req_count: got %0d beats expected 2", mon_d.size());
    end else if (mon_d[0] !== 8'hE1 || mon_d[1] !== 8'hE2 || mon_c[1] - mon_c[0] != 2) begin
      errors++;
      $display("FAIL single_req_seq: got %h %h gap %0d expected e1 e2 gap 2",
               mon_d[0], mon_d[1], mon_c[1] - mon_c[0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    idle_all();
    mon_clear();
    m_tready = 1'b1;
    set_port(1, 1'b1, 8'hD0, 1'b0);
    step();
    step();
    set_port(1, 1'b1, 8'hD1, 1'b0);
    m_tready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hD0 || s_tready !== 4'b0000) begin
        errors++;
        $display("FAIL stall%0d: v=%b d=%h s_tready=%b expected 1 d0 0000", k, m_tvalid, m_tdata, s_tready);
      end
      step();
    end
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'hD0) begin
      errors++;
      $display("FAIL stall_hold: v=%b d=%h expected 1 d0", m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    step();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'hD1) begin
      errors++;
      $display("FAIL stall_resume: v=%b d=%h expected 1 d1", m_tvalid, m_tdata);
    end
    set_port(1, 1'b1, 8'hD2, 1'b1);
    step();
    set_port(1, 1'b0, 8'h00, 1'b0);
    step();
    checks++;
    if (mon_d.size() !== 3) begin
      errors++;
      $display("FAIL stall_count: got %0d beats expected 3", mon_d.size());
    end else if (mon_d[0] !== 8'hD0 || mon_d[1] !== 8'hD1 || mon_d[2] !== 8'hD2 || mon_l[2] !== 1'b1) begin
      errors++;
      $display("FAIL stall_seq: got %h %h %h last=%b expected d0 d1 d2 last=1",
               mon_d[0], mon_d[1], mon_d[2], mon_l[2]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_midframe_stall();
    idle_all();
    mon_clear();
    m_tready = 1'b1;
    set_port(2, 1'b1, 8'h50, 1'b0);
    step();
    step();
    set_port(2, 1'b0, 8'h00, 1'b0);
    set_port(1, 1'b1, 8'hF1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_index !== 2'd2 || s_tready !== 4'b0100) begin
        errors++;
        $display("FAIL midstall%0d: gv=%b idx=%0d s_tready=%b expected 1 2 0100",
                 k, grant_valid, grant_index, s_tready);
      end
    end
    set_port(2, 1'b1, 8'h51, 1'b0);
    step();
    set_port(2, 1'b1, 8'h52, 1'b1);
    step();
    set_port(2, 1'b0, 8'h00, 1'b0);
    checks++;
    if (grant_valid !== 1'b0 || m_tdata !== 8'h52 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL midstall_end: gv=%b d=%h l=%b expected 0 52 1", grant_valid, m_tdata, m_tlast);
    end
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_index !== 2'd1) begin
      errors++;
      $display("FAIL midstall_next: gv=%b idx=%0d expected 1 1", grant_valid, grant_index);
    end
    step();
    set_port(1, 1'b0, 8'h00, 1'b0);
    step();
    checks++;
    if (mon_d.size() !== 4) begin
      errors++;
      $display("FAIL midstall_count: got %0d beats expected 4", mon_d.size());
    end else if (mon_d[0] !== 8'h50 || mon_d[1] !== 8'h51 || mon_d[2] !== 8'h52 || mon_d[3] !== 8'hF1) begin
      errors++;
      $display("FAIL midstall_seq: got %h %h %h %h expected 50 51 52 f1",
               mon_d[0], mon_d[1], mon_d[2], mon_d[3]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [7:0] exp_d [4] = '{8'h90, 8'h91, 8'h92, 8'h93};
    idle_all();
    m_tready = 1'b1;
    set_port(3, 1'b1, 8'h70, 1'b0);
    step();
    step();
    set_port(3, 1'b1, 8'h71, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || grant_valid !== 1'b0 || s_tready !== 4'b0000 || m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: v=%b gv=%b s_tready=%b d=%h expected 0 0 0000 00",
               m_tvalid, grant_valid, s_tready, m_tdata);
    end
    step();
    clear_src();
    mon_clear();
    for (int i = 0; i < S; i++) add_beat(i, exp_d[i], 1'b1);
    rst_n = 1'b1;
    pump(14);
    checks++;
    if (mon_d.size() !== 4) begin
      errors++;
      $display("FAIL post_reset_count: got %0d beats expected 4", mon_d.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= mon_d.size()) begin
        errors++;
        $display("FAIL post_reset_beat%0d: missing, expected %h", k, exp_d[k]);
      end else if (mon_d[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL post_reset_beat%0d: got %h expected %h", k, mon_d[k], exp_d[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    idle_all();
    m_tready = 1'b1;
    test_reset();
    test_single_frame();
    test_contention();
    test_fairness_wrap();
    test_single_requester();
    test_backpressure();
    test_midframe_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
